// File: rtl/trace_capture_unit_if.sv
// Snoop, control and readback bundle of the trace capture unit.
// The i_/o_ prefixes are from the capture unit's side: i_ flows into it, o_ flows out.
interface trace_capture_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
);
    localparam int IW = $clog2(DEPTH);
    localparam int DW = 3 + 4 * XLEN + 37;

    logic [XLEN-1:0] i_pc;
    logic [31:0]     i_instruction;
    logic            i_instr_valid;
    logic            i_register_write_en;
    logic [4:0]      i_rd_address;
    logic [XLEN-1:0] i_register_file_write;
    logic            i_memory_write_en;
    logic [XLEN-1:0] i_memory_write_address;
    logic [XLEN-1:0] i_memory_write;
    logic            i_arm;
    logic            i_stop_on_full;
    logic            i_rd_req;
    logic [IW-1:0]   i_rd_index;
    logic            o_rd_valid;
    logic [DW-1:0]   o_rd_data;
    logic [IW:0]     o_entry_count;
    logic            o_wrapped;
    logic            o_halted;
    logic            o_capturing;
    logic [31:0]     o_cycle_count;
    logic [31:0]     o_instret;

    modport master (
        output i_pc, i_instruction, i_instr_valid, i_register_write_en, i_rd_address,
               i_register_file_write, i_memory_write_en, i_memory_write_address,
               i_memory_write, i_arm, i_stop_on_full, i_rd_req, i_rd_index,
        input  o_rd_valid, o_rd_data, o_entry_count, o_wrapped, o_halted,
               o_capturing, o_cycle_count, o_instret
    );

    modport slave (
        input  i_pc, i_instruction, i_instr_valid, i_register_write_en, i_rd_address,
               i_register_file_write, i_memory_write_en, i_memory_write_address,
               i_memory_write, i_arm, i_stop_on_full, i_rd_req, i_rd_index,
        output o_rd_valid, o_rd_data, o_entry_count, o_wrapped, o_halted,
               o_capturing, o_cycle_count, o_instret
    );
endinterface

// File: rtl/trace_capture_unit.sv
// Retirement/trace monitor for the multicycle RV32I core: packs every active
// cycle into a circular trace RAM and keeps cycle/instret counts and halt status.
module trace_capture_unit #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 64,
    parameter int HALT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    trace_capture_unit_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int DW = 3 + 4 * XLEN + 37;
    localparam int HW = $clog2(HALT_CYCLES + 1);

    localparam logic [31:0]   HALT_INSTR = 32'h0000_006F;
    localparam logic [IW:0]   FULL_COUNT = (IW + 1)'(DEPTH);
    localparam logic [IW:0]   LAST_COUNT = (IW + 1)'(DEPTH - 1);
    localparam logic [HW-1:0] HALT_RUN   = HW'(HALT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HALTED, S_FULL} state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [IW-1:0]   r_wr_ptr;
    logic [IW:0]     r_count;
    logic            r_wrapped;
    logic            r_stop_on_full;
    logic [31:0]     r_cycle_count;
    logic [31:0]     r_instret;
    logic [XLEN-1:0] r_prev_pc;
    logic [HW-1:0]   r_pc_run;
    logic            r_rd_valid;
    logic [DW-1:0]   r_rd_data;

    logic [2:0]      w_flags;
    logic [DW-1:0]   w_entry;
    logic            w_capture;
    logic            w_write;
    logic            w_halt;
    logic [HW-1:0]   w_pc_run_next;
    logic [IW-1:0]   w_rd_phys;
    logic            w_rd_in_range;

    assign w_flags = {bus.i_memory_write_en,
                      bus.i_register_write_en && (bus.i_rd_address != 5'd0),
                      bus.i_instr_valid};

    assign w_entry = {w_flags,
                      bus.i_pc                   & {XLEN{w_flags[0]}},
                      bus.i_instruction          & {32{w_flags[0]}},
                      bus.i_rd_address           & {5{w_flags[1]}},
                      bus.i_register_file_write  & {XLEN{w_flags[1]}},
                      bus.i_memory_write_address & {XLEN{w_flags[2]}},
                      bus.i_memory_write         & {XLEN{w_flags[2]}}};

    // A run of 0 means no pc has been seen since arm, so the first CAPTURE cycle starts a run of 1.
    assign w_pc_run_next = (r_pc_run != '0 && bus.i_pc == r_prev_pc) ? r_pc_run + HW'(1) : HW'(1);

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_write      = 1'b0;
        w_halt       = 1'b0;
        if (bus.i_arm) begin
            w_state_next = S_CAPTURE;
        end else if (r_state == S_CAPTURE) begin
            w_capture = 1'b1;
            w_write   = |w_flags;
            w_halt    = (bus.i_instr_valid && bus.i_instruction == HALT_INSTR) ||
                        (w_pc_run_next == HALT_RUN);
            if (w_halt) begin
                w_state_next = S_HALTED;
            end else if (w_write && r_stop_on_full && r_count == LAST_COUNT) begin
                w_state_next = S_FULL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_wrapped      <= 1'b0;
            r_stop_on_full <= 1'b0;
            r_cycle_count  <= '0;
            r_instret      <= '0;
            r_prev_pc      <= '0;
            r_pc_run       <= '0;
        end else if (bus.i_arm) begin
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_wrapped      <= 1'b0;
            r_stop_on_full <= bus.i_stop_on_full;
            r_cycle_count  <= '0;
            r_instret      <= '0;
            r_pc_run       <= '0;
        end else if (w_capture) begin
            if (r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (w_flags[0] && r_instret != '1) begin
                r_instret <= r_instret + 32'd1;
            end
            r_prev_pc <= bus.i_pc;
            r_pc_run  <= w_pc_run_next;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + IW'(1);
                if (r_count == FULL_COUNT) begin
                    r_wrapped <= 1'b1;
                end else begin
                    r_count <= r_count + (IW + 1)'(1);
                end
            end
        end
    end

    // NOTE: the trace RAM has no reset; entry_count gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Once wrapped, the oldest entry sits at the write pointer.
    assign w_rd_phys     = (r_wrapped ? r_wr_ptr : '0) + bus.i_rd_index;
    assign w_rd_in_range = {1'b0, bus.i_rd_index} < r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= bus.i_rd_req;
            if (bus.i_rd_req) begin
                r_rd_data <= w_rd_in_range ? r_mem[w_rd_phys] : '0;
            end
        end
    end

    assign bus.o_rd_valid    = r_rd_valid;
    assign bus.o_rd_data     = r_rd_data;
    assign bus.o_entry_count = r_count;
    assign bus.o_wrapped     = r_wrapped;
    assign bus.o_halted      = (r_state == S_HALTED);
    assign bus.o_capturing   = (r_state == S_CAPTURE);
    assign bus.o_cycle_count = r_cycle_count;
    assign bus.o_instret     = r_instret;
endmodule

// File: tb/tb_trace_capture_unit.sv
// Randomised bench for trace_capture_unit: a queue-based trace model predicts status and
// read data; read responses go through a scoreboard that a negedge monitor drains.
module tb_trace_capture_unit;
    localparam int XLEN        = 32;
    localparam int DEPTH       = 4;
    localparam int HALT_CYCLES = 16;
    localparam int IW          = $clog2(DEPTH);
    localparam int DW          = 3 + 4 * XLEN + 37;

    typedef enum int {M_IDLE, M_CAPTURE, M_HALTED, M_FULL} mstate_t;
    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    trace_capture_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    trace_capture_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    rd_exp_t         exp_q[$];
    logic [DW-1:0]   m_buf[$];
    logic [XLEN-1:0] m_pc_hist[$];
    mstate_t         m_state   = M_IDLE;
    logic            m_stop    = 1'b0;
    logic            m_wrapped = 1'b0;
    logic [31:0]     m_cycles  = '0;
    logic [31:0]     m_instret = '0;
    logic            hold_pc   = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each rd_valid must match the oldest outstanding read, one cycle after its request.
    always @(negedge clk) begin : monitor
        rd_exp_t x;
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc_no) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_valid_missing: no response in cycle %0d, expected one", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.o_rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_valid_spurious: rd_valid=1 in cycle %0d, expected 0", cyc_no);
                end else begin
                    x = exp_q.pop_front();
                    check("rd_latency", DW'(cyc_no), DW'(x.cyc));
                    check("rd_data", bus.o_rd_data, x.data);
                end
            end
        end
    end

    task automatic clear_pulses();
        bus.i_instr_valid       = 1'b0;
        bus.i_register_write_en = 1'b0;
        bus.i_memory_write_en   = 1'b0;
        bus.i_arm               = 1'b0;
        bus.i_rd_req            = 1'b0;
    endtask

    task automatic model_clear();
        m_buf.delete();
        m_pc_hist.delete();
        m_wrapped = 1'b0;
        m_cycles  = '0;
        m_instret = '0;
    endtask

    task automatic check_status();
        check("entry_count", DW'(bus.o_entry_count), DW'(m_buf.size()));
        check("wrapped", DW'(bus.o_wrapped), DW'(m_wrapped));
        check("halted", DW'(bus.o_halted), DW'(m_state == M_HALTED));
        check("capturing", DW'(bus.o_capturing), DW'(m_state == M_CAPTURE));
        check("cycle_count", DW'(bus.o_cycle_count), DW'(m_cycles));
        check("instret", DW'(bus.o_instret), DW'(m_instret));
    endtask

    // Apply the spec rules to the inputs currently presented, then clock them into the DUT.
    task automatic tick();
        rd_exp_t     x;
        logic [2:0]  fl;
        logic [XLEN-1:0] f_pc, f_rdw, f_ma, f_md;
        logic [31:0] f_ins;
        logic [4:0]  f_rd;
        bit          halt;
        int          idx;
        if (bus.i_rd_req) begin
            idx    = int'(bus.i_rd_index);
            x.cyc  = cyc_no + 1;
            x.data = (idx < m_buf.size()) ? m_buf[idx] : '0;
            exp_q.push_back(x);
        end
        if (bus.i_arm) begin
            model_clear();
            m_stop  = bus.i_stop_on_full;
            m_state = M_CAPTURE;
        end else if (m_state == M_CAPTURE) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
            fl = {bus.i_memory_write_en,
                  bus.i_register_write_en && bus.i_rd_address != 5'd0,
                  bus.i_instr_valid};
            if (fl[0] && m_instret != 32'hFFFF_FFFF) m_instret++;
            if (fl != 3'b000) begin
                f_pc  = fl[0] ? bus.i_pc : '0;
                f_ins = fl[0] ? bus.i_instruction : '0;
                f_rd  = fl[1] ? bus.i_rd_address : '0;
                f_rdw = fl[1] ? bus.i_register_file_write : '0;
                f_ma  = fl[2] ? bus.i_memory_write_address : '0;
                f_md  = fl[2] ? bus.i_memory_write : '0;
                if (m_buf.size() == DEPTH) begin
                    void'(m_buf.pop_front());
                    m_wrapped = 1'b1;
                end
                m_buf.push_back({fl, f_pc, f_ins, f_rd, f_rdw, f_ma, f_md});
            end
            m_pc_hist.push_back(bus.i_pc);
            if (m_pc_hist.size() > HALT_CYCLES) void'(m_pc_hist.pop_front());
            halt = fl[0] && bus.i_instruction == 32'h0000_006F;
            if (m_pc_hist.size() == HALT_CYCLES) begin
                bit same = 1'b1;
                for (int i = 1; i < HALT_CYCLES; i++) begin
                    if (m_pc_hist[i] != m_pc_hist[0]) same = 1'b0;
                end
                if (same) halt = 1'b1;
            end
            if (halt) m_state = M_HALTED;
            else if (m_stop && m_buf.size() == DEPTH) m_state = M_FULL;
        end
        @(posedge clk);
        #1;
        clear_pulses();
        if (!hold_pc) bus.i_pc = bus.i_pc + 32'd4;
        check_status();
    endtask

    task automatic rand_event(input int p_iv, input int p_rw, input int p_mw);
        bus.i_instr_valid          = ($urandom_range(0, 99) < p_iv);
        bus.i_instruction          = $urandom();
        bus.i_register_write_en    = ($urandom_range(0, 99) < p_rw);
        bus.i_rd_address           = 5'($urandom_range(0, 31));
        bus.i_register_file_write  = $urandom();
        bus.i_memory_write_en      = ($urandom_range(0, 99) < p_mw);
        bus.i_memory_write_address = $urandom();
        bus.i_memory_write         = $urandom();
    endtask

    task automatic arm(input logic stop);
        bus.i_arm          = 1'b1;
        bus.i_stop_on_full = stop;
        tick();
    endtask

    task automatic read(input int idx);
        bus.i_rd_req   = 1'b1;
        bus.i_rd_index = IW'(idx);
        tick();
    endtask

    task automatic do_reset();
        clear_pulses();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        m_state = M_IDLE;
        check_status();
        check("rd_valid_after_reset", DW'(bus.o_rd_valid), '0);
        check("rd_data_after_reset", bus.o_rd_data, '0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.i_pc                   = 32'h0000_1000;
        bus.i_instruction          = '0;
        bus.i_rd_address           = '0;
        bus.i_register_file_write  = '0;
        bus.i_memory_write_address = '0;
        bus.i_memory_write         = '0;
        bus.i_stop_on_full         = 1'b0;
        bus.i_rd_index             = '0;
        clear_pulses();
        repeat (2) @(posedge clk);
        do_reset();
        read(0);

        // Three fetch-only cycles.
        arm(1'b0);
        repeat (3) begin
            bus.i_instr_valid = 1'b1;
            bus.i_instruction = 32'h0000_0013;
            tick();
        end
        read(0);

        // One cycle carrying fetch, register write and memory write together.
        bus.i_instr_valid          = 1'b1;
        bus.i_instruction          = 32'h0AA0_0293;
        bus.i_register_write_en    = 1'b1;
        bus.i_rd_address           = 5'd5;
        bus.i_register_file_write  = 32'h0000_00AA;
        bus.i_memory_write_en      = 1'b1;
        bus.i_memory_write_address = 32'h0000_0100;
        bus.i_memory_write         = 32'h0000_1234;
        tick();
        read(3);

        // A write to x0 alone produces no entry.
        bus.i_register_write_en   = 1'b1;
        bus.i_rd_address          = 5'd0;
        bus.i_register_file_write = 32'hDEAD_BEEF;
        tick();
        read(3);

        // Wrap mode, six events.
        arm(1'b0);
        for (int i = 0; i < 6; i++) begin
            rand_event(100, 50, 50);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) read(i);

        // Stop-on-full mode, six events.
        arm(1'b1);
        for (int i = 0; i < 6; i++) begin
            rand_event(100, 50, 50);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) read(i);

        // Halt on jal x0,0; later events must leave counters frozen.
        arm(1'b0);
        repeat (2) begin
            rand_event(100, 50, 50);
            tick();
        end
        bus.i_instr_valid = 1'b1;
        bus.i_instruction = 32'h0000_006F;
        tick();
        repeat (3) begin
            rand_event(100, 50, 50);
            tick();
        end
        read(2);

        // Halt on a pc held for HALT_CYCLES cycles, then re-arm from HALTED.
        arm(1'b0);
        hold_pc = 1'b1;
        repeat (HALT_CYCLES + 2) tick();
        hold_pc = 1'b0;
        arm(1'b0);

        // Arm coinciding with an event: the event is discarded.
        rand_event(100, 0, 0);
        tick();
        rand_event(100, 100, 100);
        bus.i_arm = 1'b1;
        tick();
        read(0);

        // Randomised traffic with occasional re-arms and reads of every index.
        for (int n = 0; n < 1500; n++) begin
            rand_event(40, 40, 30);
            if ($urandom_range(0, 99) < 2) bus.i_instruction = 32'h0000_006F;
            if ($urandom_range(0, 99) < 40) begin
                bus.i_rd_req   = 1'b1;
                bus.i_rd_index = IW'($urandom_range(0, DEPTH - 1));
            end
            if ((m_state != M_CAPTURE && $urandom_range(0, 99) < 15) || $urandom_range(0, 99) < 2) begin
                bus.i_arm          = 1'b1;
                bus.i_stop_on_full = ($urandom_range(0, 1) == 1);
            end
            tick();
        end

        // Reset in the middle of a capture.
        arm(1'b0);
        repeat (3) begin
            rand_event(100, 50, 50);
            tick();
        end
        do_reset();
        read(0);

        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rd_outstanding: %0d reads without response, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
